// File: rtl/cw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : cw_pkg                                                  |
// | Purpose    : Shared types and constants for the CW keyer sequencer.  |
// |              Holds the keyer state enumeration, the default          |
// |              envelope ramp length and a small sizing helper.         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package cw_pkg;

    // Ramp length of the transmitter CW envelope profile, in keying clocks.
    // Tied to the depth of the transmitter's profile table.
    localparam int RAMP_TICKS_DEFAULT = 511;

    // Widths of the run-time timing inputs.
    localparam int LEAD_W = 8;
    localparam int HANG_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_KEYED = 3'd2,
        ST_TAIL  = 3'd3,
        ST_HANG  = 3'd4
    } cw_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : key_debounce                                            |
// | Purpose    : Two-flop synchronizer followed by a level debouncer for |
// |              the raw CW key. The debounced level only changes after  |
// |              DEBOUNCE_TICKS consecutive synchronized samples at the  |
// |              new level; any sample back at the old level restarts.   |
// | Ports      : pro_clock - keying clock (rising edge)                  |
// |              reset     - synchronous, active-low                     |
// |              key_in    - raw asynchronous key, 1 = key down          |
// |              key_db    - debounced key level                         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic pro_clock,
    input  logic reset,
    input  logic key_in,
    output logic key_db
);

    // Counter only needs to reach DEBOUNCE_TICKS-1: the sample that would
    // make it DEBOUNCE_TICKS flips the level instead.
    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pro_clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_db = db_q;

endmodule
`default_nettype wire

// File: rtl/cw_keyer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : cw_keyer_seq                                            |
// | Purpose    : CW keying sequencer with PTT lead, envelope tail and    |
// |              semi-break-in hang. Raises PTT, waits the lead time,    |
// |              keys the transmitter, then holds PTT through the ramp   |
// |              tail and the hang time so the operator can re-key       |
// |              without dropping the transmitter.                       |
// | Ports      : pro_clock  - keying clock (rising edge)                 |
// |              reset      - synchronous, active-low                    |
// |              key_in     - raw asynchronous key, 1 = key down         |
// |              cw_enable  - CW mode enable (quasi-static)              |
// |              tx_inhibit - external TX lockout, 1 = inhibit           |
// |              ptt_lead   - PTT-to-keying lead in ticks                |
// |              hang_time  - hang time after the ramp tail, in ticks    |
// |              cw_out     - keying request to the transmitter          |
// |              ptt_out    - PTT / TX enable                            |
// |              elem_count - number of entries into the keyed state     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module cw_keyer_seq
    import cw_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int RAMP_TICKS     = RAMP_TICKS_DEFAULT
) (
    input  logic              pro_clock,
    input  logic              reset,
    input  logic              key_in,
    input  logic              cw_enable,
    input  logic              tx_inhibit,
    input  logic [LEAD_W-1:0] ptt_lead,
    input  logic [HANG_W-1:0] hang_time,
    output logic              cw_out,
    output logic              ptt_out,
    output logic [15:0]       elem_count
);

    // One shared down-counter serves lead, tail and hang; it must hold the
    // largest of the three loads.
    localparam int CNT_W = max_int($clog2(RAMP_TICKS + 1), max_int(LEAD_W, HANG_W));
    localparam logic [CNT_W-1:0] RAMP_LOAD = CNT_W'(RAMP_TICKS);

    logic            key_db;
    logic            tx_block;
    logic            key_ok;

    cw_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            cw_out_q, cw_out_d;
    logic            ptt_out_q, ptt_out_d;
    logic [15:0]     elem_count_q, elem_count_d;

    key_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .pro_clock (pro_clock),
        .reset     (reset),
        .key_in    (key_in),
        .key_db    (key_db)
    );

    always_comb begin
        tx_block = tx_inhibit || !cw_enable;
        key_ok   = key_db && !tx_block;
        state_d  = state_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (key_ok) begin
                    if (ptt_lead == '0) begin
                        state_d = ST_KEYED;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_LEAD;
                        cnt_d   = CNT_W'(ptt_lead);
                    end
                end
            end

            // Once the lead is running the element is committed: key_db is
            // ignored so the transmitter gets at least one keyed cycle. Only
            // a lockout aborts, and nothing has been ramped yet.
            ST_LEAD: begin
                if (tx_block) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_KEYED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_KEYED: begin
                if (!key_ok) begin
                    state_d = ST_TAIL;
                    cnt_d   = RAMP_LOAD;
                end
            end

            // Re-key is tested before expiry so it wins a same-cycle tie.
            // A zero hang still spends one cycle in HANG, keeping the PTT
            // release at ramp + hang + 2 ticks after cw_out falls.
            ST_TAIL: begin
                if (key_ok) begin
                    state_d = ST_KEYED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HANG;
                    cnt_d   = CNT_W'(hang_time);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_HANG: begin
                if (key_ok) begin
                    state_d = ST_KEYED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered alongside the state so they change on the
        // same edge as the state they decode.
        cw_out_d     = (state_d == ST_KEYED);
        ptt_out_d    = (state_d != ST_IDLE);
        elem_count_d = elem_count_q +
                       ((state_d == ST_KEYED && state_q != ST_KEYED) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge pro_clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cw_out_q     <= 1'b0;
            ptt_out_q    <= 1'b0;
            elem_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cw_out_q     <= cw_out_d;
            ptt_out_q    <= ptt_out_d;
            elem_count_q <= elem_count_d;
        end
    end

    assign cw_out     = cw_out_q;
    assign ptt_out    = ptt_out_q;
    assign elem_count = elem_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cw_keyer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_cw_keyer_seq                                         |
// | Purpose    : Self-checking bench for cw_keyer_seq. A timestamp-based |
// |              reference model predicts cw_out, ptt_out, elem_count    |
// |              and the debounced key every cycle; directed scenarios   |
// |              add explicit latency checks, then random episodes run.  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_cw_keyer_seq;

    localparam int DEB  = 4;
    localparam int RAMP = 511;

    logic        pro_clock = 1'b0;
    logic        reset     = 1'b0;
    logic        key_in    = 1'b0;
    logic        cw_enable = 1'b1;
    logic        tx_inhibit = 1'b0;
    logic [7:0]  ptt_lead  = 8'd0;
    logic [11:0] hang_time = 12'd0;
    logic        cw_out;
    logic        ptt_out;
    logic [15:0] elem_count;

    cw_keyer_seq #(
        .DEBOUNCE_TICKS (DEB),
        .RAMP_TICKS     (RAMP)
    ) dut (
        .pro_clock  (pro_clock),
        .reset      (reset),
        .key_in     (key_in),
        .cw_enable  (cw_enable),
        .tx_inhibit (tx_inhibit),
        .ptt_lead   (ptt_lead),
        .hang_time  (hang_time),
        .cw_out     (cw_out),
        .ptt_out    (ptt_out),
        .elem_count (elem_count)
    );

    always #5 pro_clock = ~pro_clock;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: key history window plus absolute-time bookkeeping.
    logic        m_s1, m_s2, m_db;
    logic        m_hist [DEB];
    logic        m_active, m_keyed, m_pending;
    int          m_rise_at, m_rel_at, m_hang_lat;
    logic [15:0] m_count;

    // Observed edge timestamps.
    int   t_ptt_rise, t_ptt_fall, t_cw_rise, t_cw_fall;
    int   n_ptt_rise, n_ptt_fall;
    logic prev_cw, prev_ptt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
        for (int i = 0; i < DEB; i++) m_hist[i] = 1'b0;
        m_active = 1'b0; m_keyed = 1'b0; m_pending = 1'b0;
        m_rise_at = -1; m_rel_at = -1; m_hang_lat = -1;
        m_count = 16'd0;
    endtask

    task automatic model_edge();
        logic ok;
        logic all_diff;
        ok = m_db && cw_enable && !tx_inhibit;
        if (!reset) begin
            model_clear();
        end else begin
            if (!m_active) begin
                if (ok) begin
                    m_active = 1'b1;
                    if (ptt_lead == 8'd0) begin
                        m_keyed = 1'b1;
                        m_count = m_count + 16'd1;
                    end else begin
                        m_pending = 1'b1;
                        m_rise_at = cyc + int'(ptt_lead) + 1;
                    end
                end
            end else if (m_pending) begin
                if (tx_inhibit || !cw_enable) begin
                    m_active  = 1'b0;
                    m_pending = 1'b0;
                end else if (cyc == m_rise_at) begin
                    m_pending = 1'b0;
                    m_keyed   = 1'b1;
                    m_count   = m_count + 16'd1;
                end
            end else if (m_keyed) begin
                if (!ok) begin
                    m_keyed    = 1'b0;
                    m_rel_at   = cyc;
                    m_hang_lat = -1;
                end
            end else begin
                if (ok) begin
                    m_keyed = 1'b1;
                    m_count = m_count + 16'd1;
                end else if (cyc == m_rel_at + RAMP + 1) begin
                    m_hang_lat = int'(hang_time);
                end else if (m_hang_lat >= 0 && cyc == m_rel_at + RAMP + 2 + m_hang_lat) begin
                    m_active = 1'b0;
                end
            end
            // Debounce: flip when the last DEB synchronized samples all
            // disagree with the current level.
            for (int i = 0; i < DEB - 1; i++) m_hist[i] = m_hist[i+1];
            m_hist[DEB-1] = m_s2;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    task automatic step();
        @(posedge pro_clock);
        cyc++;
        model_edge();
        #1;
        check("cw_out", 32'(cw_out), 32'(m_keyed));
        check("ptt_out", 32'(ptt_out), 32'(m_active));
        check("elem_count", 32'(elem_count), 32'(m_count));
        check("key_db", 32'(dut.key_db), 32'(m_db));
        if (ptt_out && !prev_ptt) begin t_ptt_rise = cyc; n_ptt_rise++; end
        if (!ptt_out && prev_ptt) begin t_ptt_fall = cyc; n_ptt_fall++; end
        if (cw_out && !prev_cw) t_cw_rise = cyc;
        if (!cw_out && prev_cw) t_cw_fall = cyc;
        prev_ptt = ptt_out;
        prev_cw  = cw_out;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int t_k, t_r, t_i, n_f, n_r;

    initial begin
        model_clear();
        prev_cw = 1'b0; prev_ptt = 1'b0;
        t_ptt_rise = -1; t_ptt_fall = -1; t_cw_rise = -1; t_cw_fall = -1;
        n_ptt_rise = 0; n_ptt_fall = 0;

        // Reset state
        reset = 1'b0;
        run(3);
        check("rst_cw", 32'(cw_out), 32'd0);
        check("rst_ptt", 32'(ptt_out), 32'd0);
        check("rst_count", 32'(elem_count), 32'd0);
        reset = 1'b1;
        run(2);

        // Nominal element: lead 10, hang 20, key held 100 ticks
        do_reset();
        ptt_lead = 8'd10; hang_time = 12'd20;
        key_in = 1'b1; t_k = cyc;
        run(100);
        key_in = 1'b0; t_r = cyc;
        run(560);
        check("nom_ptt_rise_lat", t_ptt_rise - t_k, 7);
        check("nom_cw_rise_lat", t_cw_rise - t_ptt_rise, 11);
        check("nom_cw_fall_lat", t_cw_fall - t_r, 7);
        check("nom_ptt_fall_lat", t_ptt_fall - t_cw_fall, RAMP + 20 + 2);
        check("nom_count", 32'(elem_count), 32'd1);

        // Short glitches from idle never get through
        do_reset();
        n_r = n_ptt_rise;
        for (int g = 0; g < 5; g++) begin
            key_in = 1'b1; run(3);
            key_in = 1'b0; run(6);
        end
        check("glitch_ptt_rises", n_ptt_rise - n_r, 0);
        check("glitch_cw", 32'(cw_out), 32'd0);

        // Re-key 200 ticks into the tail
        do_reset();
        ptt_lead = 8'd5; hang_time = 12'd30;
        key_in = 1'b1; run(40);
        key_in = 1'b0; t_r = cyc; run(7);
        check("rekey_tail_entry", t_cw_fall - t_r, 7);
        run(193);
        key_in = 1'b1; t_k = cyc; n_f = n_ptt_fall;
        run(30);
        check("rekey_cw_lat", t_cw_rise - t_k, 7);
        check("rekey_into_tail", t_cw_rise - t_cw_fall, 200);
        check("rekey_ptt_held", n_ptt_fall - n_f, 0);
        check("rekey_count", 32'(elem_count), 32'd2);
        key_in = 1'b0; run(600);

        // Inhibit mid-keyed with key held
        do_reset();
        ptt_lead = 8'd3; hang_time = 12'd15;
        key_in = 1'b1; run(30);
        tx_inhibit = 1'b1; t_i = cyc;
        run(600);
        check("inh_cw_fall_lat", t_cw_fall - t_i, 1);
        check("inh_ptt_fall_lat", t_ptt_fall - t_cw_fall, RAMP + 15 + 2);
        check("inh_no_rekey_ptt", 32'(ptt_out), 32'd0);
        check("inh_count", 32'(elem_count), 32'd1);
        key_in = 1'b0; run(10);
        tx_inhibit = 1'b0; run(5);

        // Zero lead, zero hang
        do_reset();
        ptt_lead = 8'd0; hang_time = 12'd0;
        key_in = 1'b1; run(20);
        check("z_cw_ptt_together", t_cw_rise - t_ptt_rise, 0);
        key_in = 1'b0; run(530);
        check("z_ptt_fall_lat", t_ptt_fall - t_cw_fall, RAMP + 2);

        // Reset mid-LEAD and mid-HANG
        do_reset();
        ptt_lead = 8'd20; hang_time = 12'd50;
        key_in = 1'b1; run(10);
        reset = 1'b0; step(); reset = 1'b1;
        check("rlead_cw", 32'(cw_out), 32'd0);
        check("rlead_ptt", 32'(ptt_out), 32'd0);
        check("rlead_count", 32'(elem_count), 32'd0);
        run(40);
        key_in = 1'b0; run(7 + RAMP + 10);
        reset = 1'b0; step(); reset = 1'b1;
        check("rhang_cw", 32'(cw_out), 32'd0);
        check("rhang_ptt", 32'(ptt_out), 32'd0);
        check("rhang_count", 32'(elem_count), 32'd0);
        run(10);

        // Element counter wrap
        do_reset();
        ptt_lead = 8'd2; hang_time = 12'd3;
        run(3);
        force dut.elem_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step();
        release dut.elem_count_q;
        step();
        key_in = 1'b1; run(15);
        check("wrap_count", 32'(elem_count), 32'd0);
        key_in = 1'b0; run(540);

        // Random episodes
        for (int e = 0; e < 12; e++) begin
            ptt_lead  = 8'($urandom_range(0, 12));
            hang_time = 12'($urandom_range(0, 30));
            for (int s = 0; s < 8; s++) begin
                key_in = ~key_in;
                if ($urandom_range(0, 7) == 0) tx_inhibit = ~tx_inhibit;
                if ($urandom_range(0, 9) == 0) cw_enable = ~cw_enable;
                if ($urandom_range(0, 5) == 0) ptt_lead = 8'($urandom_range(0, 12));
                if ($urandom_range(0, 5) == 0) hang_time = 12'($urandom_range(0, 30));
                if ($urandom_range(0, 29) == 0) begin
                    reset = 1'b0; step(); reset = 1'b1;
                end
                run($urandom_range(1, 60));
            end
            key_in = 1'b0; tx_inhibit = 1'b0; cw_enable = 1'b1;
            run(600);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
